// File: rtl/vx_fp_normalize.sv
// rtl/vx_fp_normalize.sv - leading-zero normalize, subnormal denormalize and overflow saturate ahead of the rounder
module vx_fp_normalize #(
    parameter int EXP_BITS  = 8,
    parameter int MAN_BITS  = 23,
    parameter int IN_MANT_W = 28,
    parameter int TAG_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         valid_in,
    output logic                         ready_in,
    input  logic                         sign_in,
    input  logic [EXP_BITS+1:0]          exp_in,
    input  logic [IN_MANT_W-1:0]         mant_in,
    input  logic                         sticky_in,
    input  logic [2:0]                   rnd_mode_in,
    input  logic                         eff_sub_in,
    input  logic [TAG_WIDTH-1:0]         tag_in,
    output logic                         valid_out,
    input  logic                         ready_out,
    output logic [EXP_BITS+MAN_BITS-1:0] abs_value_out,
    output logic [1:0]                   round_sticky_out,
    output logic                         sign_out,
    output logic [2:0]                   rnd_mode_out,
    output logic                         eff_sub_out,
    output logic [TAG_WIDTH-1:0]         tag_out,
    output logic                         overflow_out
);
    localparam int EW    = EXP_BITS + 3;
    localparam int LZC_W = $clog2(IN_MANT_W + 1);
    localparam int FW    = IN_MANT_W - 1;       // mantissa bits below the hidden position
    localparam int LOW_W = FW - MAN_BITS - 1;   // bits below the round bit
    localparam logic signed [EW-1:0] ONE     = EW'(1);
    localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_BITS) - 1);
    localparam logic signed [EW-1:0] RSH_MAX = EW'(IN_MANT_W);
    localparam logic [LZC_W-1:0]     LZ_ONE  = LZC_W'(1);
    localparam logic [EXP_BITS-1:0]  EXP_SAT = EXP_BITS'((1 << EXP_BITS) - 2);

    logic                  stall;
    logic                  s1_valid;
    logic                  s1_sign;
    logic [EXP_BITS+1:0]   s1_exp;
    logic [IN_MANT_W-1:0]  s1_mant;
    logic                  s1_sticky;
    logic [2:0]            s1_rnd_mode;
    logic                  s1_eff_sub;
    logic [TAG_WIDTH-1:0]  s1_tag;
    logic [LZC_W-1:0]      s1_lzc;
    logic [LZC_W-1:0]      lzc_in;

    assign stall    = valid_out & ~ready_out;
    assign ready_in = ~stall;

    // Last hit wins, so the highest set bit determines the count.
    always_comb begin
        lzc_in = LZC_W'(IN_MANT_W);
        for (int i = 0; i < IN_MANT_W; i++) begin
            if (mant_in[i]) begin
                lzc_in = LZC_W'(IN_MANT_W - 1 - i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid    <= 1'b0;
            s1_sign     <= 1'b0;
            s1_exp      <= '0;
            s1_mant     <= '0;
            s1_sticky   <= 1'b0;
            s1_rnd_mode <= '0;
            s1_eff_sub  <= 1'b0;
            s1_tag      <= '0;
            s1_lzc      <= '0;
        end else if (!stall) begin
            s1_valid    <= valid_in;
            s1_sign     <= sign_in;
            s1_exp      <= exp_in;
            s1_mant     <= mant_in;
            s1_sticky   <= sticky_in;
            s1_rnd_mode <= rnd_mode_in;
            s1_eff_sub  <= eff_sub_in;
            s1_tag      <= tag_in;
            s1_lzc      <= lzc_in;
        end
    end

    logic signed [EW-1:0]    exp_s;
    logic signed [EW-1:0]    lzc_s;
    logic signed [EW-1:0]    norm_exp;
    logic signed [EW-1:0]    rsh;
    logic [LZC_W-1:0]        lshift;
    logic [2*IN_MANT_W-1:0]  wide;
    logic [FW-1:0]           frac;
    logic                    shifted_sticky;
    logic [EXP_BITS-1:0]     exp_field;
    logic [MAN_BITS-1:0]     man_field;
    logic                    round_bit;
    logic                    sticky_bit;
    logic                    ovf;

    always_comb begin
        exp_s          = {s1_exp[EXP_BITS+1], s1_exp};
        lzc_s          = EW'(s1_lzc);
        norm_exp       = exp_s - lzc_s;
        rsh            = '0;
        lshift         = s1_lzc;
        wide           = '0;
        shifted_sticky = 1'b0;
        exp_field      = '0;
        frac           = FW'(s1_mant << s1_lzc);
        if (norm_exp >= ONE) begin
            exp_field = norm_exp[EXP_BITS-1:0];
        end else if (exp_s >= ONE) begin
            lshift = exp_s[LZC_W-1:0] - LZ_ONE;
            frac   = FW'(s1_mant << lshift);
        end else begin
            // Shifting by one less than the denormalizing distance keeps the
            // always-zero hidden position out of the vector.
            rsh = -exp_s;
            if (rsh > RSH_MAX) begin
                rsh = RSH_MAX;
            end
            wide           = {s1_mant, {IN_MANT_W{1'b0}}} >> rsh;
            frac           = wide[2*IN_MANT_W-1 -: FW];
            shifted_sticky = |wide[IN_MANT_W:0];
        end
        man_field  = frac[FW-1 -: MAN_BITS];
        round_bit  = frac[LOW_W];
        sticky_bit = (|frac[LOW_W-1:0]) | shifted_sticky | s1_sticky;
        ovf        = 1'b0;
        if (s1_mant == '0) begin
            exp_field  = '0;
            man_field  = '0;
            round_bit  = 1'b0;
            sticky_bit = s1_sticky;
        end else if (norm_exp >= EXP_MAX) begin
            ovf        = 1'b1;
            exp_field  = EXP_SAT;
            man_field  = '1;
            round_bit  = 1'b1;
            sticky_bit = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_out        <= 1'b0;
            abs_value_out    <= '0;
            round_sticky_out <= '0;
            sign_out         <= 1'b0;
            rnd_mode_out     <= '0;
            eff_sub_out      <= 1'b0;
            tag_out          <= '0;
            overflow_out     <= 1'b0;
        end else if (!stall) begin
            valid_out        <= s1_valid;
            abs_value_out    <= {exp_field, man_field};
            round_sticky_out <= {round_bit, sticky_bit};
            sign_out         <= s1_sign;
            rnd_mode_out     <= s1_rnd_mode;
            eff_sub_out      <= s1_eff_sub;
            tag_out          <= s1_tag;
            overflow_out     <= ovf;
        end
    end
endmodule

// File: tb/tb_vx_fp_normalize.sv
// tb/tb_vx_fp_normalize.sv - scoreboard bench for vx_fp_normalize with directed vectors
module tb_vx_fp_normalize;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        valid_in = 1'b0;
    logic        ready_in;
    logic        sign_in = 1'b0;
    logic [9:0]  exp_in = '0;
    logic [27:0] mant_in = '0;
    logic        sticky_in = 1'b0;
    logic [2:0]  rnd_mode_in = '0;
    logic        eff_sub_in = 1'b0;
    logic [7:0]  tag_in = '0;
    logic        valid_out;
    logic        ready_out = 1'b1;
    logic [30:0] abs_value_out;
    logic [1:0]  round_sticky_out;
    logic        sign_out;
    logic [2:0]  rnd_mode_out;
    logic        eff_sub_out;
    logic [7:0]  tag_out;
    logic        overflow_out;

    vx_fp_normalize #(
        .EXP_BITS(8), .MAN_BITS(23), .IN_MANT_W(28), .TAG_WIDTH(8)
    ) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
        .sign_in(sign_in), .exp_in(exp_in), .mant_in(mant_in), .sticky_in(sticky_in),
        .rnd_mode_in(rnd_mode_in), .eff_sub_in(eff_sub_in), .tag_in(tag_in),
        .valid_out(valid_out), .ready_out(ready_out), .abs_value_out(abs_value_out),
        .round_sticky_out(round_sticky_out), .sign_out(sign_out),
        .rnd_mode_out(rnd_mode_out), .eff_sub_out(eff_sub_out), .tag_out(tag_out),
        .overflow_out(overflow_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [27:0] mant;
        logic [9:0]  expo;
        logic        sticky;
        logic [30:0] abs_v;
        logic [1:0]  rs;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [30:0] abs_v;
        logic [1:0]  rs;
        logic        ovf;
        logic        sign;
        logic [2:0]  rnd;
        logic        eff_sub;
        logic [7:0]  tag;
    } exp_t;

    vec_t vecs[14];
    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   popped = 0;
    int   tag_ctr = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, req);
        end
    endtask

    task automatic bound_expired(input string name);
        checks++;
        failures++;
        $display("FAIL %s wait bound expired", name);
    endtask

    task automatic send(input int vi);
        int   waited;
        exp_t e;
        waited = 0;
        @(negedge clk);
        valid_in    = 1'b1;
        mant_in     = vecs[vi].mant;
        exp_in      = vecs[vi].expo;
        sticky_in   = vecs[vi].sticky;
        sign_in     = tag_ctr[0];
        rnd_mode_in = 3'(tag_ctr % 5);
        eff_sub_in  = tag_ctr[1];
        tag_in      = tag_ctr[7:0];
        while (!ready_in) begin
            waited++;
            if (waited > 50) begin
                bound_expired("send_ready");
                valid_in = 1'b0;
                return;
            end
            @(negedge clk);
        end
        @(posedge clk);
        e.abs_v   = vecs[vi].abs_v;
        e.rs      = vecs[vi].rs;
        e.ovf     = vecs[vi].ovf;
        e.sign    = tag_ctr[0];
        e.rnd     = 3'(tag_ctr % 5);
        e.eff_sub = tag_ctr[1];
        e.tag     = tag_ctr[7:0];
        sb.push_back(e);
        tag_ctr++;
        #1 valid_in = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) bound_expired("drain");
        @(negedge clk);
    endtask

    // Monitor: pops one expectation per accepted output beat.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && valid_out && ready_out) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output tag=%0h expected=none", tag_out);
                end else begin
                    e = sb.pop_front();
                    popped++;
                    check($sformatf("abs tag%0d", e.tag), 64'(abs_value_out), 64'(e.abs_v));
                    check($sformatf("rs tag%0d", e.tag), 64'(round_sticky_out), 64'(e.rs));
                    check($sformatf("ovf tag%0d", e.tag), 64'(overflow_out), 64'(e.ovf));
                    check($sformatf("sign tag%0d", e.tag), 64'(sign_out), 64'(e.sign));
                    check($sformatf("rnd tag%0d", e.tag), 64'(rnd_mode_out), 64'(e.rnd));
                    check($sformatf("effsub tag%0d", e.tag), 64'(eff_sub_out), 64'(e.eff_sub));
                    check("tag_order", 64'(tag_out), 64'(e.tag));
                end
            end
        end
    end

    initial begin
        int p0;
        vecs[0]  = '{28'h8000000, 10'd127,  1'b0, 31'h3F800000, 2'b00, 1'b0};
        vecs[1]  = '{28'h0000001, 10'd127,  1'b0, 31'h32000000, 2'b00, 1'b0};
        vecs[2]  = '{28'h4000001, 10'd1,    1'b0, 31'h00400000, 2'b01, 1'b0};
        vecs[3]  = '{28'h8000000, 10'd255,  1'b0, 31'h7F7FFFFF, 2'b11, 1'b1};
        vecs[4]  = '{28'h0000000, 10'd50,   1'b1, 31'h00000000, 2'b01, 1'b0};
        vecs[5]  = '{28'hFFFFFFF, 10'd127,  1'b0, 31'h3FFFFFFF, 2'b11, 1'b0};
        vecs[6]  = '{28'h8000000, 10'd0,    1'b0, 31'h00400000, 2'b00, 1'b0};
        vecs[7]  = '{28'h8000000, 10'h3E2,  1'b0, 31'h00000000, 2'b01, 1'b0};
        vecs[8]  = '{28'h0000100, 10'd5,    1'b0, 31'h00000100, 2'b00, 1'b0};
        vecs[9]  = '{28'h8000000, 10'd254,  1'b0, 31'h7F000000, 2'b00, 1'b0};
        vecs[10] = '{28'h4000000, 10'd256,  1'b0, 31'h7F7FFFFF, 2'b11, 1'b1};
        vecs[11] = '{28'h8000008, 10'd127,  1'b1, 31'h3F800000, 2'b11, 1'b0};
        vecs[12] = '{28'h8000000, 10'd1,    1'b0, 31'h00800000, 2'b00, 1'b0};
        vecs[13] = '{28'h8000004, 10'd127,  1'b0, 31'h3F800000, 2'b01, 1'b0};

        repeat (3) @(negedge clk);
        check("rst_valid_out", 64'(valid_out), 64'd0);
        check("rst_abs", 64'(abs_value_out), 64'd0);
        check("rst_rs", 64'(round_sticky_out), 64'd0);
        check("rst_ovf", 64'(overflow_out), 64'd0);
        check("rst_tag", 64'(tag_out), 64'd0);
        check("rst_ready_in", 64'(ready_in), 64'd1);
        reset = 1'b1;

        for (int i = 0; i < 14; i++) send(i);
        drain();
        check("directed_count", 64'(popped), 64'd14);

        // Backpressure: four back-to-back ops, output held off for three cycles.
        p0 = popped;
        fork
            begin
                for (int i = 0; i < 4; i++) send(i);
            end
            begin
                repeat (3) @(posedge clk);
                #1 ready_out = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_ready_in", 64'(ready_in), 64'd0);
                    check("stall_valid_out", 64'(valid_out), 64'd1);
                end
                @(posedge clk);
                #1 ready_out = 1'b1;
            end
        join
        drain();
        check("bp_count", 64'(popped - p0), 64'd4);

        // Reset with two ops in flight.
        send(5);
        send(9);
        reset = 1'b0;
        #1;
        check("midrst_valid_out", 64'(valid_out), 64'd0);
        check("midrst_abs", 64'(abs_value_out), 64'd0);
        check("midrst_tag", 64'(tag_out), 64'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("post_rst_idle", 64'(valid_out), 64'd0);
        end
        p0 = popped;
        send(0);
        drain();
        check("post_rst_count", 64'(popped - p0), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
